// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential divider.
// Holds the controller state encoding and the WIDTH/STEP legality check.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // WIDTH must be even and at least 4; STEP must split WIDTH into whole cycles.
  function automatic bit div_params_ok(int width, int step);
    return (width >= 4) && ((width % 2) == 0) &&
           (step >= 1) && (step <= width) && ((width % step) == 0);
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: request/result bundle of the sequential divider.
// master drives the request (start, operands, mode); slave returns status and results.
interface div_seq_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             unsigned_op;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, a, b, unsigned_op,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, a, b, unsigned_op,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits. The shifted value is WIDTH+1 bits so the compare never
// truncates; the sign of the WIDTH+1 bit difference is the compare result.
// Caller guarantees rem_in < divisor, which keeps the shifted value below
// 2*divisor and the restored remainder within WIDTH bits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dvd_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction; a non-negative difference sets the quotient bit.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for the HI/LO unit.
// Retires STEP quotient bits per cycle; quotient on lo, remainder on hi.
// Optional feature macro: DIV_SEQ_UNSIGNED_EN (honour unsigned_op; otherwise
// every operation is signed and unsigned_op is ignored).
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input logic       clk,
  input logic       reset,
  div_seq_if.slave  bus
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_FIX  = 2'(FIX);

  if (!div_params_ok(WIDTH, STEP)) begin : g_bad_params
    $error("div_seq: WIDTH must be even and >= 4, and STEP must divide WIDTH");
  end

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] qd;
  logic [WIDTH-1:0] rem;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             done_r;
  logic             dz_r;

  // Operand signs and magnitudes, evaluated only when a start is accepted.
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    a_neg;
  logic                    b_neg;
  logic [WIDTH-1:0]        a_mag;
  logic [WIDTH-1:0]        b_mag;

  assign a_s = bus.a;
  assign b_s = bus.b;

`ifdef DIV_SEQ_UNSIGNED_EN
  assign a_neg = (a_s < 0) && !bus.unsigned_op;
  assign b_neg = (b_s < 0) && !bus.unsigned_op;
`else
  logic unused_mode;
  assign unused_mode = bus.unsigned_op;
  assign a_neg = (a_s < 0);
  assign b_neg = (b_s < 0);
`endif

  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  // Per-cycle chain of STEP restoring steps. qd holds the dividend bits still
  // to be consumed at the top and the quotient bits produced so far at the bottom.
  logic [WIDTH-1:0] rem_c [STEP+1];
  logic [WIDTH-1:0] qd_c  [STEP+1];
  logic [STEP-1:0]  qb;

  assign rem_c[0] = rem;
  assign qd_c[0]  = qd;

  for (genvar k = 0; k < STEP; k++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_c[k]),
      .divisor (dvs),
      .dvd_bit (qd_c[k][WIDTH-1]),
      .rem_out (rem_c[k+1]),
      .q_bit   (qb[k])
    );
    assign qd_c[k+1] = {qd_c[k][WIDTH-2:0], qb[k]};
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

  // Controller and datapath: accept in IDLE, iterate in RUN, sign-fix in FIX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      dvs    <= '0;
      qd     <= '0;
      rem    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            dz_r <= (bus.b == '0);
            if (bus.b == '0) begin
              // Divide by zero: report immediately, results untouched.
              done_r <= 1'b1;
            end else begin
              dvs   <= b_mag;
              qd    <= a_mag;
              rem   <= '0;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              cnt   <= CW'(N);
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          rem <= rem_c[STEP];
          qd  <= qd_c[STEP];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          lo_r   <= q_neg ? -qd : qd;
          hi_r   <= r_neg ? -rem : rem;
          done_r <= 1'b1;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq at 32/1 and 32/4.
// Expected results come from plain integer division in the model function.
module tb_div_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start1;
  logic        start4;
  logic [31:0] a_d;
  logic [31:0] b_d;
  logic        uns_d;
  bit          sel_cur;

  div_seq_if #(.WIDTH(32)) if1 ();
  div_seq_if #(.WIDTH(32)) if4 ();

  assign if1.start       = start1;
  assign if1.a           = a_d;
  assign if1.b           = b_d;
  assign if1.unsigned_op = uns_d;
  assign if4.start       = start4;
  assign if4.a           = a_d;
  assign if4.b           = b_d;
  assign if4.unsigned_op = uns_d;

  div_seq #(.WIDTH(32), .STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  div_seq #(.WIDTH(32), .STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

  logic        busy_s, done_s, dz_s;
  logic [31:0] hi_s, lo_s;
  assign busy_s = sel_cur ? if4.busy     : if1.busy;
  assign done_s = sel_cur ? if4.done     : if1.done;
  assign dz_s   = sel_cur ? if4.div_zero : if1.div_zero;
  assign hi_s   = sel_cur ? if4.hi       : if1.hi;
  assign lo_s   = sel_cur ? if4.lo       : if1.lo;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] prev_hi [2];
  logic [31:0] prev_lo [2];
  logic [31:0] pend_hi, pend_lo;
  logic        pend_dz;
  int          pend_lat, pend_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer division, quotient truncated toward zero, remainder
  // takes the dividend's sign; results wrap to 32 bits.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit uns);
    longint      sa, sb, q, r;
    int          ia, ib;
    logic [31:0] lo, hi;
    bit          u;
    u = uns;
`ifndef DIV_SEQ_UNSIGNED_EN
    u = 1'b0;
`endif
    if (u) begin
      lo = a / b;
      hi = a % b;
    end else begin
      ia = a;
      ib = b;
      sa = ia;
      sb = ib;
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
    return {hi, lo};
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start4 = v;
    else     start1 = v;
  endtask

  task automatic launch(input bit sel, input logic [31:0] a, input logic [31:0] b, input bit uns);
    logic [63:0] m;
    sel_cur = sel;
    a_d     = a;
    b_d     = b;
    uns_d   = uns;
    set_start(sel, 1'b1);
    if (b == 32'd0) begin
      pend_hi   = prev_hi[sel];
      pend_lo   = prev_lo[sel];
      pend_dz   = 1'b1;
      pend_lat  = 1;
      pend_busy = 0;
    end else begin
      m         = model(a, b, uns);
      pend_hi   = m[63:32];
      pend_lo   = m[31:0];
      pend_dz   = 1'b0;
      pend_lat  = (sel ? 8 : 32) + 2;
      pend_busy = pend_lat - 1;
    end
    prev_hi[sel] = pend_hi;
    prev_lo[sel] = pend_lo;
  endtask

  task automatic wait_done(input bit poke);
    int lat, nb;
    @(posedge clk);
    @(negedge clk);
    set_start(sel_cur, 1'b0);
    lat = 1;
    nb  = 0;
    while (!done_s && lat < 100) begin
      if (busy_s) nb++;
      if (poke && lat == 3) begin
        a_d = 32'd5;
        b_d = 32'd1;
        set_start(sel_cur, 1'b1);
      end else if (poke && lat == 4) begin
        set_start(sel_cur, 1'b0);
      end
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(pend_lat));
    check("busy_cycles", 64'(nb), 64'(pend_busy));
    check("busy_at_done", 64'(busy_s), 64'd0);
    check("lo", 64'(lo_s), 64'(pend_lo));
    check("hi", 64'(hi_s), 64'(pend_hi));
    check("div_zero", 64'(dz_s), 64'(pend_dz));
  endtask

  task automatic op(input bit sel, input logic [31:0] a, input logic [31:0] b, input bit uns, input bit poke);
    @(negedge clk);
    launch(sel, a, b, uns);
    wait_done(poke);
    @(negedge clk);
    check("done_pulse", 64'(done_s), 64'd0);
    check("idle_after", 64'(busy_s), 64'd0);
  endtask

  task automatic check_zero(input string tag, input bit sel);
    sel_cur = sel;
    #0;
    check({tag, "_busy"}, 64'(busy_s), 64'd0);
    check({tag, "_done"}, 64'(done_s), 64'd0);
    check({tag, "_dz"},   64'(dz_s),   64'd0);
    check({tag, "_hi"},   64'(hi_s),   64'd0);
    check({tag, "_lo"},   64'(lo_s),   64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs, ru;
    reset  = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    a_d    = '0;
    b_d    = '0;
    uns_d  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prev_hi[i] = '0;
      prev_lo[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_zero("rst1", 1'b0);
    check_zero("rst4", 1'b1);
    reset = 1'b1;

    // Signed directed cases at one bit per cycle.
    op(1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
    op(1'b0, -32'd100, 32'd7, 1'b0, 1'b0);
    op(1'b0, 32'd100, -32'd7, 1'b0, 1'b0);
    op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Divide by zero keeps previous results; next valid start clears the flag.
    op(1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
    op(1'b0, 32'd55, 32'd0, 1'b0, 1'b0);
    op(1'b0, 32'd9, 32'd3, 1'b0, 1'b0);

    // Unsigned request; result depends on the build option.
    op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);

    // Four bits per cycle, with a start attempted mid-operation.
    op(1'b1, 32'd1000, 32'd3, 1'b0, 1'b1);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    launch(1'b1, 32'd1000, 32'd3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_reset", 64'(if4.busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_zero("midrst4", 1'b1);
    check_zero("midrst1", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      prev_hi[i] = '0;
      prev_lo[i] = '0;
    end
    op(1'b1, 32'd1000, 32'd3, 1'b0, 1'b0);
    op(1'b0, 32'd1, 32'd0, 1'b0, 1'b0);

    // Back-to-back: new start accepted in the done cycle.
    @(negedge clk);
    launch(1'b0, 32'd77, 32'd5, 1'b0);
    wait_done(1'b0);
    launch(1'b0, -32'd50, 32'd3, 1'b0);
    wait_done(1'b0);
    @(negedge clk);
    check("b2b_done_pulse", 64'(done_s), 64'd0);

    // Randomised operations on both instances.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 9);
        2:       rb = 32'd0 - $urandom_range(1, 9);
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      op(rs, ra, rb, ru, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
